ram_io: RTL and testbench
=========================

# ram_io

Load/store alignment stage between the RISC-V core's memory port and the unified instruction/data cache. Converts byte, half-word and word accesses at any byte address into word-aligned cache accesses with 4-bit byte-enable masks. Splits accesses that straddle a 4-byte boundary into two sequential cache accesses. For loads, it assembles, shifts and sign- or zero-extends the returned data.

## Interface
- `AccessWidthBits`, 2: width of the `width` encoding.
- `SettleCycles`, 1: cycles each cache sub-access is held before its result is sampled (minimum 1; covers tag/BRAM read latency).

Ports. One clock; reset is synchronous and active-low.
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `enable`  in  1  request valid; `address`, `width`, `write`, `sign_extend` and `data_in` are held while `busy`
- `address`  in  32  byte address
- `width`  in  2  00 none, 01 byte, 10 half, 11 word
- `write`  in  1  1 = store, 0 = load
- `sign_extend`  in  1  load result sign-extended when 1
- `data_in`  in  32  store data, right-justified
- `data_out`  out  32  load result, valid while `data_out_ready`
- `data_out_ready`  out  1  one-cycle completion strobe (loads and stores)
- `busy`  out  1  request in progress
- `cache_enable`  out  1  to cache `enable`
- `cache_address`  out  32  word-aligned (`[1:0]` = 00)
- `cache_data_in`  out  32  lane-shifted store data
- `cache_write_enable`  out  4  byte mask; 0 for loads
- `cache_data_out`  in  32  cache read word
- `cache_data_out_ready`  in  1  cache read hit
- `cache_busy`  in  1  cache line fill or eviction in progress

## Operation
- Lane math:
  - `off = address[1:0]`
  - `wmask` = 0001 / 0011 / 1111 for byte / half / word
  - `m8 = {4'b0, wmask} << off` (8 bits)
  - `d64 = {32'b0, data_in} << (8*off)`
  - lo mask `m8[3:0]` with data `d64[31:0]`; hi mask `m8[7:4]` with data `d64[63:32]`
  - `split = m8[7:4] != 0`
- Lo access address: `{address[31:2], 2'b00}`. Hi access address: lo + 4, modulo 2^32, so 0xFFFF_FFFC wraps to 0x0000_0000.
- Load result: `({hi_word, lo_word} >> 8*off)` truncated to width, then extended per `sign_extend`. `hi_word` is treated as 0 when not split.
- States:
  - `Idle`: on `enable && width != 00`, register the request and go to `Lo`. `width == 00` is ignored and the block stays `Idle`.
  - `Lo`: drive the lo access. After `SettleCycles`, wait for completion.
    - Load completion: `cache_data_out_ready`; capture `lo_word`.
    - Store completion: `!cache_busy`.
    - Then go to `Hi` if split, else `Done`.
  - `Hi`: same as `Lo` for the hi access; capture `hi_word`; go to `Done`.
  - `Done`: `data_out_ready = 1` for one cycle, `busy = 0`; go to `Idle`.
- `busy` = (state != `Idle` && state != `Done`) or (`Idle` && `enable && width != 00`). It is asserted combinationally in the request cycle.
- `cache_enable` is deasserted for exactly one cycle between `Lo` and `Hi`, so the cache re-evaluates the new line.
- The settle counter restarts whenever `cache_busy` rises during an access. After a fill, the result is resampled, not taken from the stale cycle.
- A store never masks more than the addressed lanes. Untouched bytes in both words are preserved by the cache.

## Timing
- Reset values: state `Idle`; `busy` 0, `data_out_ready` 0, `data_out` 0, `cache_enable` 0, `cache_write_enable` 0, `cache_address` 0, `cache_data_in` 0.
- Aligned hit, `SettleCycles = 1`: request at cycle 0, cache access at cycles 1–2, `data_out_ready` at cycle 3.
- Split hit: `data_out_ready` at cycle 6 (two accesses plus the one-cycle gap).
- A miss adds the cache's fill/eviction time to the affected sub-access only.
- `data_out` holds its value after `Done` until the next load completes.
- Reset in any state returns to `Idle` at the next edge. `cache_write_enable` is 0 from that edge on. A store interrupted between `Lo` and `Hi` leaves only the lo bytes written; this is accepted.
- A new request may be presented in the cycle after `Done`.

## Structure
- Shared package `ram_io_pkg`: `width_e` enum (`WidthNone`, `WidthByte`, `WidthHalf`, `WidthWord`) and state typedef. The core's decoder uses the same enum.
- One natural combinational sub-module, `byte_lane_align`. It covers both directions: masks and shifted data for stores, shift and extend for loads.

## Test plan
- Aligned word store then load at 0x0000_1000, data 0xDEAD_BEEF: one write access with mask 1111; load returns 0xDEAD_BEEF; `data_out_ready` at cycle 3.
- Byte store 0xA5 at 0x0000_1002 over 0xDEAD_BEEF: mask 0100, `cache_data_in` 0x00A5_0000. A signed byte load at 0x1002 returns 0xFFFF_FFA5; an unsigned one returns 0x0000_00A5.
- Word store 0x1122_3344 at 0x0000_1003: lo mask 1000 with data 0x4400_0000; hi access at 0x1004 with mask 0111 and data 0x0011_2233. Reload returns 0x1122_3344.
- Split half load at 0xFFFF_FFFF: accesses at 0xFFFF_FFFC then 0x0000_0000; the result combines byte 3 of the first word with byte 0 of the second.
- `cache_busy` asserted for 12 cycles during `Hi` (miss with dirty eviction): no early strobe; correct data after the fill; exactly one `data_out_ready` pulse.
- `rst_n` low during `Hi` of a split store: next cycle `Idle`, `cache_write_enable` 0, `busy` 0; the hi word is not written.

Source files
------------

// File: rtl/ram_io_pkg.sv
// Shared types for the load/store alignment stage and the core's decoder.
package ram_io_pkg;

   typedef enum logic [1:0] {
      WidthNone = 2'b00,
      WidthByte = 2'b01,
      WidthHalf = 2'b10,
      WidthWord = 2'b11
   } width_e;

   typedef enum logic [2:0] {
      StIdle,
      StLo,
      StGap,
      StHi,
      StDone
   } state_e;

   // Byte-enable pattern of an access before it is shifted into its lanes.
   function automatic logic [3:0] width_mask(input width_e w);
      logic [3:0] m;
      case (w)
         WidthByte: m = 4'b0001;
         WidthHalf: m = 4'b0011;
         WidthWord: m = 4'b1111;
         default:   m = 4'b0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/ram_io_byte_lane_align.sv
// Byte-lane steering: store masks/data for both words, load shift and extend.
module byte_lane_align
   import ram_io_pkg::*;
(
   input  logic [1:0]  offset_i,
   input  logic [1:0]  width_i,
   input  logic        sign_extend_i,
   input  logic [31:0] store_data_i,
   input  logic [31:0] lo_word_i,
   input  logic [23:0] hi_word_i,
   output logic [3:0]  lo_mask_o,
   output logic [3:0]  hi_mask_o,
   output logic [31:0] lo_data_o,
   output logic [31:0] hi_data_o,
   output logic        split_o,
   output logic [31:0] load_data_o
);

   logic [7:0]  m8;
   logic [63:0] d64;
   logic [31:0] shifted;

   // Lane masks, lane-shifted store data and the assembled, extended load value.
   // The top byte of the hi word can never be reached by a 4-byte access, so it is not an input.
   always_comb begin
      m8  = {4'b0000, width_mask(width_e'(width_i))} << offset_i;
      d64 = {32'h0000_0000, store_data_i} << {offset_i, 3'b000};

      case (offset_i)
         2'd0:    shifted = lo_word_i;
         2'd1:    shifted = {hi_word_i[7:0],  lo_word_i[31:8]};
         2'd2:    shifted = {hi_word_i[15:0], lo_word_i[31:16]};
         default: shifted = {hi_word_i[23:0], lo_word_i[31:24]};
      endcase

      case (width_e'(width_i))
         WidthByte: load_data_o = {{24{sign_extend_i & shifted[7]}},  shifted[7:0]};
         WidthHalf: load_data_o = {{16{sign_extend_i & shifted[15]}}, shifted[15:0]};
         WidthWord: load_data_o = shifted;
         default:   load_data_o = '0;
      endcase
   end

   assign lo_mask_o = m8[3:0];
   assign hi_mask_o = m8[7:4];
   assign lo_data_o = d64[31:0];
   assign hi_data_o = d64[63:32];
   assign split_o   = (m8[7:4] != 4'b0000);

endmodule

// File: rtl/ram_io.sv
// Load/store alignment stage: turns unaligned core accesses into one or two
// word-aligned cache accesses with byte-enable masks.
module ram_io
   import ram_io_pkg::*;
#(
   parameter int AccessWidthBits = 2,
   parameter int SettleCycles    = 1
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       enable,
   input  logic [31:0]                address,
   input  logic [AccessWidthBits-1:0] width,
   input  logic                       write,
   input  logic                       sign_extend,
   input  logic [31:0]                data_in,
   output logic [31:0]                data_out,
   output logic                       data_out_ready,
   output logic                       busy,
   output logic                       cache_enable,
   output logic [31:0]                cache_address,
   output logic [31:0]                cache_data_in,
   output logic [3:0]                 cache_write_enable,
   input  logic [31:0]                cache_data_out,
   input  logic                       cache_data_out_ready,
   input  logic                       cache_busy
);

   localparam int CntW = (SettleCycles < 1) ? 1 : $clog2(SettleCycles + 1);

   state_e                     state_q;
   logic [31:0]                addr_q;
   logic [31:0]                data_q;
   logic [31:0]                lo_word_q;
   logic [AccessWidthBits-1:0] width_q;
   logic                       write_q;
   logic                       sext_q;
   logic [CntW-1:0]            cnt_q;

   logic [31:0] data_out_q;
   logic        ready_q;
   logic        cache_en_q;
   logic [31:0] cache_addr_q;
   logic [31:0] cache_din_q;
   logic [3:0]  cache_we_q;

   logic                       in_idle;
   logic                       req_valid;
   logic [31:0]                req_addr;
   logic [31:0]                req_data;
   logic [AccessWidthBits-1:0] req_width;
   logic                       req_sext;
   logic [31:0]                lo_in;
   logic [23:0]                hi_in;
   logic [3:0]                 lo_mask;
   logic [3:0]                 hi_mask;
   logic [31:0]                lo_data;
   logic [31:0]                hi_data;
   logic                       split;
   logic [31:0]                load_data;
   logic                       settled;
   logic                       access_ok;

   assign in_idle   = (state_q == StIdle);
   assign req_valid = enable && (width != '0);

   // In Idle the aligner sees the live request so the lo access can start on the next edge.
   always_comb begin
      req_addr  = in_idle ? address     : addr_q;
      req_data  = in_idle ? data_in     : data_q;
      req_width = in_idle ? width       : width_q;
      req_sext  = in_idle ? sign_extend : sext_q;
      lo_in     = (state_q == StLo) ? cache_data_out       : lo_word_q;
      hi_in     = (state_q == StHi) ? cache_data_out[23:0] : '0;
      settled   = (cnt_q == CntW'(SettleCycles));
      access_ok = write_q ? !cache_busy : cache_data_out_ready;
      busy      = (state_q == StLo) || (state_q == StGap) || (state_q == StHi)
                  || (in_idle && req_valid);
   end

   byte_lane_align u_align (
      .offset_i      (req_addr[1:0]),
      .width_i       (req_width),
      .sign_extend_i (req_sext),
      .store_data_i  (req_data),
      .lo_word_i     (lo_in),
      .hi_word_i     (hi_in),
      .lo_mask_o     (lo_mask),
      .hi_mask_o     (hi_mask),
      .lo_data_o     (lo_data),
      .hi_data_o     (hi_data),
      .split_o       (split),
      .load_data_o   (load_data)
   );

   // Access sequencer: Idle -> Lo -> (Gap -> Hi) -> Done, all cache-facing outputs registered.
   // cache_busy zeroes the settle counter so data after a fill is sampled afresh.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         addr_q       <= '0;
         data_q       <= '0;
         lo_word_q    <= '0;
         width_q      <= '0;
         write_q      <= 1'b0;
         sext_q       <= 1'b0;
         cnt_q        <= '0;
         data_out_q   <= '0;
         ready_q      <= 1'b0;
         cache_en_q   <= 1'b0;
         cache_addr_q <= '0;
         cache_din_q  <= '0;
         cache_we_q   <= '0;
      end else begin
         ready_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  addr_q       <= address;
                  data_q       <= data_in;
                  width_q      <= width;
                  write_q      <= write;
                  sext_q       <= sign_extend;
                  cnt_q        <= '0;
                  cache_en_q   <= 1'b1;
                  cache_addr_q <= {address[31:2], 2'b00};
                  cache_din_q  <= lo_data;
                  cache_we_q   <= write ? lo_mask : 4'b0000;
                  state_q      <= StLo;
               end
            end
            StLo, StHi: begin
               if (cache_busy) begin
                  cnt_q <= '0;
               end else if (!settled) begin
                  cnt_q <= cnt_q + CntW'(1);
               end else if (access_ok) begin
                  cache_en_q <= 1'b0;
                  cache_we_q <= '0;
                  if (state_q == StLo) begin
                     lo_word_q <= cache_data_out;
                  end
                  if ((state_q == StLo) && split) begin
                     state_q <= StGap;
                  end else begin
                     state_q <= StDone;
                     ready_q <= 1'b1;
                     if (!write_q) begin
                        data_out_q <= load_data;
                     end
                  end
               end
            end
            StGap: begin
               cnt_q        <= '0;
               cache_en_q   <= 1'b1;
               cache_addr_q <= {addr_q[31:2], 2'b00} + 32'd4;
               cache_din_q  <= hi_data;
               cache_we_q   <= write_q ? hi_mask : 4'b0000;
               state_q      <= StHi;
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign data_out           = data_out_q;
   assign data_out_ready     = ready_q;
   assign cache_enable       = cache_en_q;
   assign cache_address      = cache_addr_q;
   assign cache_data_in      = cache_din_q;
   assign cache_write_enable = cache_we_q;

endmodule

// File: tb/tb_ram_io.sv
// Bench for ram_io: behavioural byte-addressed memory model plus a simple
// cache model with one-cycle read latency and an injectable miss.
module tb_ram_io;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic [31:0] address = '0;
   logic [1:0]  width = '0;
   logic        write = 1'b0;
   logic        sign_extend = 1'b0;
   logic [31:0] data_in = '0;
   logic [31:0] data_out;
   logic        data_out_ready;
   logic        busy;
   logic        cache_enable;
   logic [31:0] cache_address;
   logic [31:0] cache_data_in;
   logic [3:0]  cache_write_enable;
   logic [31:0] cache_data_out = '0;
   logic        cache_data_out_ready = 1'b0;
   logic        cache_busy;

   ram_io #(.AccessWidthBits(2), .SettleCycles(1)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .enable               (enable),
      .address              (address),
      .width                (width),
      .write                (write),
      .sign_extend          (sign_extend),
      .data_in              (data_in),
      .data_out             (data_out),
      .data_out_ready       (data_out_ready),
      .busy                 (busy),
      .cache_enable         (cache_enable),
      .cache_address        (cache_address),
      .cache_data_in        (cache_data_in),
      .cache_write_enable   (cache_write_enable),
      .cache_data_out       (cache_data_out),
      .cache_data_out_ready (cache_data_out_ready),
      .cache_busy           (cache_busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- memory contents ----------------
   logic [31:0] cmem [bit [31:0]];
   logic [7:0]  rmem [bit [31:0]];

   function automatic logic [31:0] init_word(input logic [31:0] wa);
      return (wa * 32'h9E37_79B1) ^ 32'hA5C3_0F17;
   endfunction

   function automatic logic [31:0] rd_word(input logic [31:0] wa);
      if (cmem.exists(wa)) return cmem[wa];
      return init_word(wa);
   endfunction

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      logic [31:0] w;
      if (rmem.exists(a)) return rmem[a];
      w = init_word({a[31:2], 2'b00}) >> (8 * a[1:0]);
      return w[7:0];
   endfunction

   function automatic int nbytes(input logic [1:0] w);
      return (w == 2'd1) ? 1 : (w == 2'd2) ? 2 : 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] w, input logic sx);
      logic [31:0] v = '0;
      int n = nbytes(w);
      for (int i = 0; i < n; i++) v = v | (32'(ref_byte(a + 32'(i))) << (8 * i));
      if (sx && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
      return v;
   endfunction

   // ---------------- cache model ----------------
   int          busy_left = 0;
   int          held = 0;
   logic        prev_ce = 1'b0;
   bit          miss_arm = 0;
   logic [31:0] miss_addr = '0;

   assign cache_busy = (busy_left != 0);

   // One-cycle read latency; a write commits only once the access has been held a cycle.
   always @(posedge clk) begin
      logic [31:0] w;
      prev_ce <= cache_enable;
      if (cache_enable && !prev_ce && miss_arm && cache_address == miss_addr) begin
         busy_left <= 12;
         miss_arm <= 0;
         held <= 0;
         cache_data_out_ready <= 1'b0;
      end else if (busy_left != 0) begin
         busy_left <= busy_left - 1;
         held <= 0;
         cache_data_out_ready <= 1'b0;
      end else begin
         cache_data_out_ready <= cache_enable;
         cache_data_out <= rd_word(cache_address);
         if (cache_enable) begin
            if (held != 0 && cache_write_enable != 4'b0000) begin
               w = rd_word(cache_address);
               for (int b = 0; b < 4; b++)
                  if (cache_write_enable[b]) w[8*b +: 8] = cache_data_in[8*b +: 8];
               cmem[cache_address] = w;
            end
            held <= held + 1;
         end else begin
            held <= 0;
         end
      end
   end

   // ---------------- request driver ----------------
   int          acc_n;
   logic [31:0] acc_addr [4];
   logic [31:0] acc_mask [4];
   logic [31:0] acc_data [4];
   logic [31:0] last_load = '0;

   task automatic run_req(input logic [31:0] a, input logic [1:0] w, input logic wr, input logic sx,
                          input logic [31:0] d, output int lat, output int pulses, output logic [31:0] rdata);
      bit ce_prev = 0;
      bit got = 0;
      @(negedge clk);
      address = a; width = w; write = wr; sign_extend = sx; data_in = d; enable = 1'b1;
      #1 check_eq("busy_req", busy, 1);
      lat = -1; pulses = 0; rdata = '0; acc_n = 0;
      for (int c = 1; c <= 300; c++) begin
         @(posedge clk); #1;
         if (cache_enable && !ce_prev && acc_n < 4) begin
            acc_addr[acc_n] = cache_address;
            acc_mask[acc_n] = 32'(cache_write_enable);
            acc_data[acc_n] = cache_data_in;
            acc_n++;
         end
         ce_prev = cache_enable;
         if (data_out_ready) begin
            pulses++;
            if (!got) begin
               got = 1; lat = c; rdata = data_out; enable = 1'b0;
            end
         end
         if (got && c >= lat + 3) break;
      end
      enable = 1'b0;
      if (!got) check_eq("timeout", 0, 1);
   endtask

   task automatic do_op(input logic [31:0] a, input logic [1:0] w, input logic wr, input logic sx,
                        input logic [31:0] d, input int exp_lat, input int min_lat, output logic [31:0] rdata);
      int n = nbytes(w);
      bit split = (int'(a[1:0]) + n) > 4;
      logic [31:0] exp_v = ref_load(a, w, sx);
      logic [31:0] lo_a = {a[31:2], 2'b00};
      int lat, pulses;
      run_req(a, w, wr, sx, d, lat, pulses, rdata);
      check_eq("pulses", pulses, 1);
      if (exp_lat >= 0) check_eq("latency", lat, exp_lat);
      else check_eq("latency_min", 32'(lat >= min_lat), 1);
      check_eq("n_access", acc_n, split ? 2 : 1);
      check_eq("lo_addr", acc_addr[0], lo_a);
      if (split) check_eq("hi_addr", acc_addr[1], lo_a + 32'd4);
      if (!wr) begin
         check_eq("load_data", rdata, exp_v);
         check_eq("load_mask", acc_mask[0], 0);
         last_load = exp_v;
      end else begin
         check_eq("data_hold", rdata, last_load);
         for (int i = 0; i < n; i++) rmem[a + 32'(i)] = 8'(d >> (8 * i));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] r;
      logic [31:0] a;
      logic [1:0]  w;
      int          seen;
      bit          hit;

      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_ready", data_out_ready, 0);
      check_eq("rst_dout", data_out, 0);
      check_eq("rst_ce", cache_enable, 0);
      check_eq("rst_we", cache_write_enable, 0);
      check_eq("rst_caddr", cache_address, 0);
      check_eq("rst_cdin", cache_data_in, 0);
      @(negedge clk) rst_n = 1'b1;

      // aligned word store / load
      do_op(32'h0000_1000, 2'd3, 1, 0, 32'hDEAD_BEEF, 3, 0, r);
      check_eq("sw_mask", acc_mask[0], 32'hF);
      check_eq("sw_data", acc_data[0], 32'hDEAD_BEEF);
      do_op(32'h0000_1000, 2'd3, 0, 0, 0, 3, 0, r);
      check_eq("lw_const", r, 32'hDEAD_BEEF);

      // byte store into lane 2, signed and unsigned reload
      do_op(32'h0000_1002, 2'd1, 1, 0, 32'h0000_00A5, 3, 0, r);
      check_eq("sb_mask", acc_mask[0], 32'h4);
      check_eq("sb_data", acc_data[0], 32'h00A5_0000);
      do_op(32'h0000_1002, 2'd1, 0, 1, 0, 3, 0, r);
      check_eq("lb_signed", r, 32'hFFFF_FFA5);
      do_op(32'h0000_1002, 2'd1, 0, 0, 0, 3, 0, r);
      check_eq("lb_unsigned", r, 32'h0000_00A5);

      // split word store at offset 3
      do_op(32'h0000_1003, 2'd3, 1, 0, 32'h1122_3344, 6, 0, r);
      check_eq("split_lo_mask", acc_mask[0], 32'h8);
      check_eq("split_lo_data", acc_data[0], 32'h4400_0000);
      check_eq("split_hi_mask", acc_mask[1], 32'h7);
      check_eq("split_hi_data", acc_data[1], 32'h0011_2233);
      do_op(32'h0000_1003, 2'd3, 0, 0, 0, 6, 0, r);
      check_eq("split_reload", r, 32'h1122_3344);

      // half load wrapping the address space
      do_op(32'hFFFF_FFFF, 2'd2, 0, 0, 0, 6, 0, r);
      check_eq("wrap_hi_addr", acc_addr[1], 32'h0000_0000);

      // miss with long fill during the hi access
      miss_addr = 32'h0000_1004; miss_arm = 1;
      do_op(32'h0000_1003, 2'd3, 0, 1, 0, -1, 17, r);
      check_eq("miss_data", r, 32'h1122_3344);

      // width none is ignored
      @(negedge clk);
      address = 32'h0000_1000; width = 2'd0; write = 0; enable = 1'b1;
      #1 check_eq("none_busy", busy, 0);
      seen = 0;
      repeat (4) begin
         @(posedge clk); #1;
         if (cache_enable || data_out_ready) seen++;
      end
      check_eq("none_idle", seen, 0);
      enable = 1'b0;

      // reset at the start of the hi access of a split store
      @(negedge clk);
      address = 32'h0000_2002; width = 2'd3; write = 1; sign_extend = 0;
      data_in = 32'hCAFE_F00D; enable = 1'b1;
      seen = 0; hit = 0;
      begin
         bit pce = 0;
         for (int c = 0; c < 50 && !hit; c++) begin
            @(posedge clk); #1;
            if (cache_enable && !pce) seen++;
            pce = cache_enable;
            if (seen == 2) begin
               rst_n = 1'b0; enable = 1'b0; hit = 1;
            end
         end
      end
      if (!hit) check_eq("rst_reach_hi", 0, 1);
      @(posedge clk); #1;
      check_eq("rst_hi_busy", busy, 0);
      check_eq("rst_hi_we", cache_write_enable, 0);
      check_eq("rst_hi_ce", cache_enable, 0);
      check_eq("rst_hi_ready", data_out_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      rmem[32'h0000_2002] = 8'h0D;
      rmem[32'h0000_2003] = 8'hF0;
      last_load = '0;
      do_op(32'h0000_2000, 2'd3, 0, 0, 0, 3, 0, r);
      do_op(32'h0000_2004, 2'd3, 0, 0, 0, 3, 0, r);

      // randomized traffic
      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFF8 + $urandom_range(0, 7);
         else a = 32'h0000_3000 + $urandom_range(0, 31);
         w = 2'($urandom_range(1, 3));
         do_op(a, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
               ((int'(a[1:0]) + nbytes(w)) > 4) ? 6 : 3, 0, r);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
